// File: rtl/fetch_unit.sv
// Instruction-fetch stage: four-phase strobe generator, program counter,
// instruction register and circular return-address stack.
module fetch_unit #(
  parameter int PC_WIDTH     = 8,
  parameter int INST_WIDTH   = 8,
  parameter int RESET_VECTOR = 0,
  parameter int STACK_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic [INST_WIDTH-1:0] prog_data,
  input  logic                  branch_en,
  input  logic                  call_en,
  input  logic                  ret_en,
  input  logic                  skip_en,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  clk1,
  output logic                  clk2,
  output logic                  clk3,
  output logic                  clk4,
  output logic [PC_WIDTH-1:0]   prog_addr,
  output logic [INST_WIDTH-1:0] inst_reg,
  output logic                  inst_valid,
  output logic                  stack_ovf
);

  localparam int SPW = $clog2(STACK_DEPTH);
  localparam int CW  = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] RV   = PC_WIDTH'(RESET_VECTOR);
  localparam logic [CW-1:0]       FULL = CW'(STACK_DEPTH);

  typedef enum logic [1:0] {Q1 = 2'd0, Q2 = 2'd1, Q3 = 2'd2, Q4 = 2'd3} phase_e;

  phase_e                phase_q, phase_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [INST_WIDTH-1:0] ir_q, ir_d;
  logic                  vld_q, vld_d;
  logic [SPW-1:0]        sp_q, sp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [PC_WIDTH-1:0]   stack_q [STACK_DEPTH];
  logic [PC_WIDTH-1:0]   stack_d [STACK_DEPTH];

  logic [PC_WIDTH-1:0]   pc_inc;
  logic [SPW-1:0]        top;

  // sp points at the next free slot; the top of stack sits one below it.
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign top    = sp_q - SPW'(1);

  always_comb begin
    phase_d = phase_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    vld_d   = vld_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    stack_d = stack_q;

    if (!hold) begin
      unique case (phase_q)
        Q1: phase_d = Q2;
        Q2: phase_d = Q3;
        Q3: phase_d = Q4;
        Q4: phase_d = Q1;
        default: phase_d = Q1;
      endcase

      if (phase_q == Q4) begin
        // Any redirect or skip flushes the prefetched instruction.
        ir_d  = '0;
        vld_d = 1'b0;
        if (ret_en) begin
          pc_d  = stack_q[top];
          sp_d  = top;
          cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        end else if (call_en) begin
          stack_d[sp_q] = pc_q;
          sp_d          = sp_q + SPW'(1);
          pc_d          = branch_target;
          if (cnt_q == FULL) ovf_d = 1'b1;
          else               cnt_d = cnt_q + CW'(1);
        end else if (branch_en) begin
          pc_d = branch_target;
        end else if (skip_en) begin
          pc_d = pc_inc;
        end else begin
          pc_d  = pc_inc;
          ir_d  = prog_data;
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= Q1;
      pc_q    <= RV;
      ir_q    <= '0;
      vld_q   <= 1'b0;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      stack_q <= stack_d;
    end
  end

  assign clk1       = (phase_q == Q1);
  assign clk2       = (phase_q == Q2);
  assign clk3       = (phase_q == Q3);
  assign clk4       = (phase_q == Q4);
  assign prog_addr  = pc_q;
  assign inst_reg   = ir_q;
  assign inst_valid = vld_q;
  assign stack_ovf  = ovf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the instruction-cycle rules.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n, hold;
  logic [7:0] prog_data;
  logic       branch_en, call_en, ret_en, skip_en;
  logic [7:0] branch_target;
  logic       clk1, clk2, clk3, clk4;
  logic [7:0] prog_addr, inst_reg;
  logic       inst_valid, stack_ovf;

  logic [7:0] rom [256];
  assign prog_data = rom[prog_addr];

  fetch_unit #(.PC_WIDTH(8), .INST_WIDTH(8), .RESET_VECTOR(0), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .prog_data(prog_data),
    .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en), .skip_en(skip_en),
    .branch_target(branch_target),
    .clk1(clk1), .clk2(clk2), .clk3(clk3), .clk4(clk4),
    .prog_addr(prog_addr), .inst_reg(inst_reg), .inst_valid(inst_valid),
    .stack_ovf(stack_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: phase is a cycle index 0..3, stack is a ring addressed modulo 4.
  int         m_ph;
  logic [7:0] m_pc, m_ir;
  logic       m_vld, m_ovf;
  logic [7:0] m_stk [4];
  int         m_sp, m_cnt;

  function automatic void m_reset();
    m_ph = 0; m_pc = 8'h00; m_ir = 8'h00; m_vld = 1'b0; m_ovf = 1'b0;
    m_sp = 0; m_cnt = 0;
    for (int i = 0; i < 4; i++) m_stk[i] = 8'h00;
  endfunction

  function automatic void m_step();
    if (hold) return;
    if (m_ph == 3) begin
      m_ir = 8'h00; m_vld = 1'b0;
      if (ret_en) begin
        m_sp  = (m_sp + 3) % 4;
        m_pc  = m_stk[m_sp];
        m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
      end else if (call_en) begin
        m_stk[m_sp] = m_pc;
        m_sp = (m_sp + 1) % 4;
        if (m_cnt == 4) m_ovf = 1'b1; else m_cnt++;
        m_pc = branch_target;
      end else if (branch_en) begin
        m_pc = branch_target;
      end else if (skip_en) begin
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end else begin
        m_ir  = rom[m_pc];
        m_vld = 1'b1;
        m_pc  = 8'((int'(m_pc) + 1) % 256);
      end
    end
    m_ph = (m_ph + 1) % 4;
  endfunction

  function automatic logic [21:0] obs();
    return {clk1, clk2, clk3, clk4, prog_addr, inst_reg, inst_valid, stack_ovf};
  endfunction

  function automatic logic [21:0] expv();
    logic [3:0] oh;
    oh = 4'b1000 >> m_ph;
    return {oh, m_pc, m_ir, m_vld, m_ovf};
  endfunction

  task automatic tick();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic goto_phase(input int p);
    for (int i = 0; i < 4 && m_ph != p; i++) tick();
  endtask

  task automatic q4_event(input logic b, input logic c, input logic r, input logic s,
                          input logic [7:0] t);
    goto_phase(3);
    branch_en = b; call_en = c; ret_en = r; skip_en = s; branch_target = t;
    tick();
    branch_en = 0; call_en = 0; ret_en = 0; skip_en = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) rom[i] = 8'(i + 16);
    rst_n = 0; hold = 0; branch_en = 0; call_en = 0; ret_en = 0; skip_en = 0;
    branch_target = 8'h00;
    #3; m_reset();
    checks++;
    if (obs() !== expv()) begin
      failures++; $display("FAIL reset_state got=%h exp=%h", obs(), expv());
    end
    @(negedge clk); rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || !$onehot({clk1, clk2, clk3, clk4})) begin
        failures++; $display("FAIL reset_rotate edge=%0d got=%h exp=%h", i, obs(), expv());
      end
      if (i == 4 || i == 8) begin
        checks++;
        if (inst_reg !== ((i == 4) ? 8'h10 : 8'h11) || inst_valid !== 1'b1) begin
          failures++; $display("FAIL first_fetch edge=%0d got=%h/%b", i, inst_reg, inst_valid);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] seen [3];
    int n = 0;
    q4_event(1, 0, 0, 0, 8'hFE);
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL wrap_step got=%h exp=%h", obs(), expv());
      end
      if (m_ph == 0 && n < 3) begin seen[n] = inst_reg; n++; end
    end
    checks++;
    if (seen[0] !== 8'h0E || seen[1] !== 8'h0F || seen[2] !== 8'h10) begin
      failures++; $display("FAIL wrap_order got=%h %h %h exp=0e 0f 10", seen[0], seen[1], seen[2]);
    end
  endtask

  task automatic test_branch();
    q4_event(1, 0, 0, 0, 8'h40);
    checks++;
    if (inst_reg !== 8'h00 || inst_valid !== 1'b0 || obs() !== expv()) begin
      failures++; $display("FAIL branch_flush got=%h exp=%h", obs(), expv());
    end
    goto_phase(3); tick();
    checks++;
    if (inst_reg !== 8'h50 || inst_valid !== 1'b1 || prog_addr !== 8'h41) begin
      failures++; $display("FAIL branch_target got=%h/%h exp=50/41", inst_reg, prog_addr);
    end
  endtask

  task automatic test_skip();
    q4_event(1, 0, 0, 0, 8'h05);
    q4_event(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (obs() !== expv() || inst_reg === 8'h15) begin
        failures++; $display("FAIL skip_step got=%h exp=%h", obs(), expv());
      end
    end
    checks++;
    if (inst_reg !== 8'h16 || inst_valid !== 1'b1) begin
      failures++; $display("FAIL skip_next got=%h exp=16", inst_reg);
    end
  endtask

  task automatic test_call_ret();
    q4_event(1, 0, 0, 0, 8'h21);
    q4_event(0, 1, 0, 0, 8'h80);
    checks++;
    if (prog_addr !== 8'h80 || inst_valid !== 1'b0 || obs() !== expv()) begin
      failures++; $display("FAIL call_redirect got=%h exp=%h", obs(), expv());
    end
    q4_event(0, 0, 1, 0, 8'h00);
    checks++;
    if (prog_addr !== 8'h21 || stack_ovf !== 1'b0) begin
      failures++; $display("FAIL ret_pc got=%h exp=21", prog_addr);
    end
    goto_phase(3); tick();
    checks++;
    if (inst_reg !== 8'h31 || obs() !== expv()) begin
      failures++; $display("FAIL ret_resume got=%h exp=31", inst_reg);
    end
    for (int k = 0; k < 5; k++) q4_event(0, 1, 0, 0, 8'(8'h80 + k));
    checks++;
    if (stack_ovf !== 1'b1 || obs() !== expv()) begin
      failures++; $display("FAIL nest_ovf got=%h exp=%h", obs(), expv());
    end
    for (int k = 0; k < 5; k++) begin
      q4_event(0, 0, 1, 0, 8'h00);
      checks++;
      if (prog_addr !== ((k == 4) ? 8'h83 : 8'(8'h83 - k)) || obs() !== expv()) begin
        failures++; $display("FAIL nest_ret k=%0d got=%h exp=%h", k, obs(), expv());
      end
    end
  endtask

  task automatic test_hold_reset();
    logic [21:0] snap;
    goto_phase(1);
    snap = obs();
    hold = 1;
    branch_en = 1; branch_target = 8'hAA;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (obs() !== snap || obs() !== expv()) begin
        failures++; $display("FAIL hold_frozen got=%h exp=%h", obs(), snap);
      end
    end
    branch_en = 0; hold = 0;
    tick();
    checks++;
    if (clk3 !== 1'b1 || obs() !== expv()) begin
      failures++; $display("FAIL hold_resume got=%h exp=%h", obs(), expv());
    end
    #2; rst_n = 0; #1;
    m_reset();
    checks++;
    if (obs() !== expv() || stack_ovf !== 1'b0 || clk1 !== 1'b1) begin
      failures++; $display("FAIL async_reset got=%h exp=%h", obs(), expv());
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (inst_reg !== 8'h10 || obs() !== expv()) begin
      failures++; $display("FAIL reset_restart got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 800; i++) begin
      hold          = ($urandom_range(0, 9) == 0);
      branch_en     = ($urandom_range(0, 5) == 0);
      call_en       = ($urandom_range(0, 5) == 0);
      ret_en        = ($urandom_range(0, 5) == 0);
      skip_en       = ($urandom_range(0, 5) == 0);
      branch_target = 8'($urandom);
      tick();
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    hold = 0; branch_en = 0; call_en = 0; ret_en = 0; skip_en = 0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_branch();
    test_skip();
    test_call_ret();
    test_hold_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
